// File: rtl/seq_ctrl_if.sv
// Sequencer-side bundle: start/done handshake, ROM fetch, branch resolve, data-memory handshake.
// PW sets the program-counter and branch-target width and must match the sequencer's PW.
interface seq_ctrl_if #(
    parameter int PW = 8
);
    logic          Req;
    logic          Ack;
    logic [8:0]    instr;
    logic [PW-1:0] pc;
    logic [8:0]    ir;
    logic          br_taken;
    logic [PW-1:0] br_target;
    logic          mem_req;
    logic          mem_we;
    logic          mem_ack;
    logic          rf_we;
    logic [15:0]   cycle_cnt;

    modport master (
        input  Req, instr, br_taken, br_target, mem_ack,
        output Ack, pc, ir, mem_req, mem_we, rf_we, cycle_cnt
    );

    modport slave (
        output Req, instr, br_taken, br_target, mem_ack,
        input  Ack, pc, ir, mem_req, mem_we, rf_we, cycle_cnt
    );
endinterface

// File: rtl/seq_ctrl.sv
// Multi-cycle sequencer: owns PC/IR, resolves bne, stalls on data-memory handshakes; optional SEQ_CYCLE_CNT_EN run counter.
// Latency: 2 cycles per ALU/branch instruction, 3+N per load/store (N = mem_ack wait cycles); Ack the cycle after the last one.
// Backpressure: MEM holds mem_req/mem_we until mem_ack; DONE holds Ack until Req drops.
module seq_ctrl #(
    parameter int PW       = 8,
    parameter int PROG_LEN = 256
) (
    input  logic       Clk,
    input  logic       Reset,
    seq_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, DONE} state_t;

    localparam logic [2:0] OP_BNE = 3'b011;
    localparam logic [2:0] OP_LD  = 3'b110;
    localparam logic [2:0] OP_ST  = 3'b111;
    // One extra bit so that PROG_LEN == 2**PW is still reachable.
    localparam logic [PW:0] END_PC = (PW+1)'(PROG_LEN);

    state_t        state_q, state_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [8:0]    ir_q, ir_d;

    logic [2:0]    op;
    logic          is_mem;
    logic [PW:0]   pc_inc_w;
    logic          end_inc;
    logic          end_br;
    logic          mem_req_w;
    logic          mem_we_w;
    logic          rf_we_w;
    logic          ack_w;

    assign op       = ir_q[8:6];
    assign is_mem   = (op == OP_LD) || (op == OP_ST);
    assign pc_inc_w = {1'b0, pc_q} + (PW+1)'(1);
    assign end_inc  = (pc_inc_w == END_PC);
    assign end_br   = ({1'b0, bus.br_target} == END_PC);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        mem_req_w = 1'b0;
        mem_we_w  = 1'b0;
        rf_we_w   = 1'b0;
        ack_w     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Req) begin
                    pc_d    = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                ir_d    = bus.instr;
                state_d = EXEC;
            end
            EXEC: begin
                if (is_mem) begin
                    mem_req_w = 1'b1;
                    mem_we_w  = (op == OP_ST);
                    state_d   = MEM;
                end else if (op == OP_BNE) begin
                    if (bus.br_taken) begin
                        pc_d    = bus.br_target;
                        state_d = end_br ? DONE : FETCH;
                    end else begin
                        pc_d    = pc_inc_w[PW-1:0];
                        state_d = end_inc ? DONE : FETCH;
                    end
                end else begin
                    rf_we_w = 1'b1;
                    pc_d    = pc_inc_w[PW-1:0];
                    state_d = end_inc ? DONE : FETCH;
                end
            end
            MEM: begin
                mem_req_w = 1'b1;
                mem_we_w  = (op == OP_ST);
                if (bus.mem_ack) begin
                    rf_we_w = (op == OP_LD);
                    pc_d    = pc_inc_w[PW-1:0];
                    state_d = end_inc ? DONE : FETCH;
                end
            end
            DONE: begin
                ack_w = 1'b1;
                if (!bus.Req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    assign bus.pc      = pc_q;
    assign bus.ir      = ir_q;
    assign bus.mem_req = mem_req_w;
    assign bus.mem_we  = mem_we_w;
    assign bus.rf_we   = rf_we_w;
    assign bus.Ack     = ack_w;

`ifdef SEQ_CYCLE_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Cleared on start, saturating while the run is active, frozen otherwise.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE && bus.Req) begin
            cnt_d = '0;
        end else if ((state_q == FETCH || state_q == EXEC || state_q == MEM) && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.cycle_cnt = cnt_q;
`else
    assign bus.cycle_cnt = '0;
`endif
endmodule

// File: tb/tb_seq_ctrl.sv
// Bench for seq_ctrl: a PW=8 and a PW=2 instance (both PROG_LEN=4) run the same programs in lockstep;
// an expected per-cycle trace is queued at start of each run and popped against both instances every cycle.
module tb_seq_ctrl;
    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    seq_ctrl_if #(.PW(8)) ifa ();
    seq_ctrl_if #(.PW(2)) ifw ();

    seq_ctrl #(.PW(8), .PROG_LEN(4)) u_a (.Clk(Clk), .Reset(Reset), .bus(ifa));
    seq_ctrl #(.PW(2), .PROG_LEN(4)) u_w (.Clk(Clk), .Reset(Reset), .bus(ifw));

    logic [8:0] rom [4];
    int         wt  [4];
    logic [7:0] tgt;
    logic       req;
    logic       spur;
    logic       br_arm;
    logic       used_a, used_w;
    int         mcnt_a, mcnt_w;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int pc;
        bit rf_we;
        bit mem_req;
        bit mem_we;
        bit ack;
        int ir;
        bit ir_vld;
    } exp_t;

    exp_t exp_q[$];

    // ROM, branch unit and data memory models
    assign ifa.Req       = req;
    assign ifw.Req       = req;
    assign ifa.instr     = rom[ifa.pc[1:0]];
    assign ifw.instr     = rom[ifw.pc];
    assign ifa.br_target = tgt;
    assign ifw.br_target = tgt[1:0];
    assign ifa.br_taken  = br_arm & ~used_a;
    assign ifw.br_taken  = br_arm & ~used_w;
    assign ifa.mem_ack   = spur | (ifa.mem_req && mcnt_a == 1 + wt[ifa.pc[1:0]]);
    assign ifw.mem_ack   = spur | (ifw.mem_req && mcnt_w == 1 + wt[ifw.pc]);

    // The branch at pc 2 is taken only on its first execution.
    always @(posedge Clk) begin
        if (Reset) begin
            used_a <= 1'b0;
            used_w <= 1'b0;
            mcnt_a <= 0;
            mcnt_w <= 0;
        end else begin
            if (ifa.pc == 8'd2 && ifa.ir[8:6] == 3'b011) used_a <= 1'b1;
            if (ifw.pc == 2'd2 && ifw.ir[8:6] == 3'b011) used_w <= 1'b1;
            mcnt_a <= ifa.mem_req ? mcnt_a + 1 : 0;
            mcnt_w <= ifw.mem_req ? mcnt_w + 1 : 0;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " a.pc"}, ifa.pc, 0);           chk({nm, " w.pc"}, ifw.pc, 0);
        chk({nm, " a.ir"}, ifa.ir, 0);           chk({nm, " w.ir"}, ifw.ir, 0);
        chk({nm, " a.Ack"}, ifa.Ack, 0);         chk({nm, " w.Ack"}, ifw.Ack, 0);
        chk({nm, " a.mem_req"}, ifa.mem_req, 0); chk({nm, " w.mem_req"}, ifw.mem_req, 0);
        chk({nm, " a.mem_we"}, ifa.mem_we, 0);   chk({nm, " w.mem_we"}, ifw.mem_we, 0);
        chk({nm, " a.rf_we"}, ifa.rf_we, 0);     chk({nm, " w.rf_we"}, ifw.rf_we, 0);
        chk({nm, " a.cnt"}, ifa.cycle_cnt, 0);   chk({nm, " w.cnt"}, ifw.cycle_cnt, 0);
    endtask

    task automatic do_reset(input string nm);
        Reset = 1'b1;
        req   = 1'b0;
        @(posedge Clk); #1;
        chk_zero(nm);
        Reset = 1'b0;
    endtask

    // Reference sequencing: one entry per clock from the first FETCH to the last DONE cycle.
    task automatic build_trace(input int n_done, output int active);
        int   p, np, op;
        bit   arm;
        exp_t e;
        p = 0; np = 0; active = 0; arm = br_arm;
        for (int guard = 0; guard < 32; guard++) begin
            op = int'(rom[p][8:6]);
            e = '{pc: p, rf_we: 0, mem_req: 0, mem_we: 0, ack: 0, ir: 0, ir_vld: 0};
            exp_q.push_back(e); active++;
            e.ir = int'(rom[p]); e.ir_vld = 1;
            if (op >= 6) begin
                e.mem_req = 1; e.mem_we = (op == 7);
                exp_q.push_back(e); active++;
                for (int k = 0; k <= wt[p]; k++) begin
                    e.rf_we = (k == wt[p]) && (op == 6);
                    exp_q.push_back(e); active++;
                end
                np = p + 1;
            end else if (op == 3) begin
                exp_q.push_back(e); active++;
                np = (p == 2 && arm) ? int'(tgt) : p + 1;
                if (p == 2) arm = 0;
            end else begin
                e.rf_we = 1;
                exp_q.push_back(e); active++;
                np = p + 1;
            end
            if (np == 4) break;
            p = np;
        end
        e = '{pc: np, rf_we: 0, mem_req: 0, mem_we: 0, ack: 1, ir: 0, ir_vld: 0};
        repeat (n_done) exp_q.push_back(e);
    endtask

    task automatic cmp(input string nm, input int idx, input exp_t e, input int ec);
        string t;
        t = $sformatf("%s[%0d]", nm, idx);
        chk({t, " a.pc"}, ifa.pc, e.pc & 255);       chk({t, " w.pc"}, ifw.pc, e.pc & 3);
        chk({t, " a.rf_we"}, ifa.rf_we, e.rf_we);     chk({t, " w.rf_we"}, ifw.rf_we, e.rf_we);
        chk({t, " a.mem_req"}, ifa.mem_req, e.mem_req); chk({t, " w.mem_req"}, ifw.mem_req, e.mem_req);
        chk({t, " a.mem_we"}, ifa.mem_we, e.mem_we);  chk({t, " w.mem_we"}, ifw.mem_we, e.mem_we);
        chk({t, " a.Ack"}, ifa.Ack, e.ack);           chk({t, " w.Ack"}, ifw.Ack, e.ack);
        if (e.ir_vld) begin
            chk({t, " a.ir"}, ifa.ir, e.ir);          chk({t, " w.ir"}, ifw.ir, e.ir);
        end
        if (e.ack) begin
            chk({t, " a.cnt"}, ifa.cycle_cnt, ec);    chk({t, " w.cnt"}, ifw.cycle_cnt, ec);
        end
    endtask

    task automatic run_prog(input string nm, input int n_done);
        int   active, idx, ec;
        exp_t e;
        exp_q.delete();
        build_trace(n_done, active);
`ifdef SEQ_CYCLE_CNT_EN
        ec = active;
`else
        ec = 0;
`endif
        req = 1'b1;
        @(posedge Clk); #1;
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp(nm, idx, e, ec);
            idx++;
            if (exp_q.size() > 0) begin
                @(posedge Clk); #1;
            end
        end
        req = 1'b0;
        @(posedge Clk); #1;
        chk({nm, " idle a.Ack"}, ifa.Ack, 0);         chk({nm, " idle w.Ack"}, ifw.Ack, 0);
        chk({nm, " idle a.mem_req"}, ifa.mem_req, 0); chk({nm, " idle w.mem_req"}, ifw.mem_req, 0);
    endtask

    task automatic load_straight();
        for (int i = 0; i < 4; i++) begin
            rom[i] = 9'b001_000101;
            wt[i]  = 0;
        end
    endtask

    initial begin
        Reset = 1'b1; req = 1'b0; spur = 1'b0; br_arm = 1'b0; tgt = 8'd0;
        load_straight();
        do_reset("rst0");

        // Straight-line adds; a stray mem_ack held high must be ignored.
        spur = 1'b1;
        run_prog("line", 2);
        spur = 1'b0;

        // bne at pc 2: taken to 0 on the first pass, falls through on the second.
        do_reset("rst1");
        rom[0] = 9'b001_000001; rom[1] = 9'b010_000010; rom[2] = 9'b011_000001; rom[3] = 9'b100_000011;
        br_arm = 1'b1;
        run_prog("bne", 3);
        br_arm = 1'b0;

        // Load with two wait cycles, then zero-wait store.
        do_reset("rst2");
        rom[0] = 9'b000_000001; rom[1] = 9'b110_000010; rom[2] = 9'b111_000011; rom[3] = 9'b101_000100;
        wt[1] = 2; wt[2] = 0;
        run_prog("mem", 1);

        // Reset while a load is stalled in MEM, then restart from pc 0.
        do_reset("rst3");
        load_straight();
        rom[0] = 9'b110_000001;
        wt[0]  = 5;
        req = 1'b1;
        repeat (3) begin
            @(posedge Clk); #1;
        end
        chk("stall a.mem_req", ifa.mem_req, 1);
        chk("stall w.mem_req", ifw.mem_req, 1);
        Reset = 1'b1; req = 1'b0;
        @(posedge Clk); #1;
        chk_zero("midrst");
        Reset = 1'b0;
        load_straight();
        run_prog("restart", 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
